guess_game_ctrl: RTL and testbench

//  Sequencer between the keypad decode path (debounced key -> 4-bit code + valid pulse) and the
//  4-digit 7-seg display driver. Collects a BCD guess, compares it with a latched secret,

---
 rtl/guess_pkg.sv | 25 ++
 rtl/guess_game_ctrl_if.sv | 24 ++
 rtl/guess_entry_buffer.sv | 53 +++++
 rtl/guess_game_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/guess_pkg.sv
// Shared definitions for the guess game controller: state encodings,
// keypad codes and a digit test helper.
`timescale 1ns/1ps
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    WRONG = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_e;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_NEW   = 4'hF;

  // True for a decimal digit key / BCD nibble.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Keypad / display bundle between the decode path, the game controller
// and the 7-seg driver. master = stimulus side, slave = controller.
`timescale 1ns/1ps
interface guess_game_ctrl_if #(parameter int N_DIGITS = 4);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic [4*N_DIGITS-1:0] secret_in;
  logic [4*N_DIGITS-1:0] disp_data;
  logic [N_DIGITS-1:0]   disp_blank;
  logic [7:0]            tries;
  logic                  win;
  logic                  lose;
  logic [2:0]            state_o;

  modport master (
    output key_valid, key_code, secret_in,
    input  disp_data, disp_blank, tries, win, lose, state_o
  );

  modport slave (
    input  key_valid, key_code, secret_in,
    output disp_data, disp_blank, tries, win, lose, state_o
  );
endinterface

// File: rtl/guess_entry_buffer.sv
// Nibble shift register holding the guess being typed. Digits enter at
// nibble 0 and push older digits left; pop undoes the last push.
// Priority: clear > push > pop. Push when full / pop when empty are no-ops.
// Next-state values are exported so the owner can register outputs that
// reflect a key in the same cycle the buffer takes it.
`timescale 1ns/1ps
module guess_entry_buffer #(
  parameter int N_DIGITS = 4,
  parameter int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [3:0]            din,
  output logic [4*N_DIGITS-1:0] value,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic [4*N_DIGITS-1:0] value_nxt,
  output logic [CW-1:0]         count_nxt
);
  localparam int W = 4 * N_DIGITS;

  assign full = (count == CW'(N_DIGITS));

  // Next buffer contents from the requested operation.
  always_comb begin
    value_nxt = value;
    count_nxt = count;
    if (clr) begin
      value_nxt = '0;
      count_nxt = '0;
    end else if (push && !full) begin
      value_nxt = (value << 4) | W'(din);
      count_nxt = count + 1'b1;
    end else if (pop && (count != '0)) begin
      value_nxt = value >> 4;
      count_nxt = count - 1'b1;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else begin
      value <= value_nxt;
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/guess_game_ctrl.sv
// Guess game sequencer: collects a BCD guess from keypad codes, compares
// it to a latched secret, counts tries and drives the 7-seg display.
// All outputs are flops loaded from next-state values, so a key shows up
// on the outputs one cycle after its key_valid pulse.
// Optional feature: define BLINK_EN to blink the display in WIN/LOSE.
`timescale 1ns/1ps
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int MAX_TRIES = 8,
  parameter int SHOW_CYC  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input logic              clk_50M,
  input logic              RST,
  guess_game_ctrl_if.slave io
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

  if (MAX_TRIES < 1 || MAX_TRIES > 255 || SHOW_CYC < 1 || BLINK_DIV < 1) begin : g_bad_params
    $error("guess_game_ctrl: parameter out of range");
  end

  state_e         state, state_nxt;
  logic [7:0]     tries_q, tries_nxt, tries_inc;
  logic [TW-1:0]  timer, timer_nxt;
  logic [W-1:0]   secret, secret_nxt;

  logic           buf_clr, buf_push, buf_pop, buf_full;
  logic [W-1:0]   buf_value, buf_value_nxt;
  logic [CW-1:0]  buf_count, buf_count_nxt;

  logic           secret_ok, new_game;

  logic [W-1:0]        disp_data_q, disp_data_nxt;
  logic [N_DIGITS-1:0] disp_blank_q, disp_blank_nxt, blink_mask;
  logic                win_q, lose_q;

  guess_entry_buffer #(.N_DIGITS(N_DIGITS), .CW(CW)) u_buf (
    .clk       (clk_50M),
    .rst       (RST),
    .clr       (buf_clr),
    .push      (buf_push),
    .pop       (buf_pop),
    .din       (io.key_code),
    .value     (buf_value),
    .count     (buf_count),
    .full      (buf_full),
    .value_nxt (buf_value_nxt),
    .count_nxt (buf_count_nxt)
  );

  // A new-game secret is only usable if every nibble is a decimal digit.
  always_comb begin
    secret_ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++)
      if (!is_digit(io.secret_in[4*i +: 4])) secret_ok = 1'b0;
  end

  // F restarts from any state but CHECK, where key input is dropped.
  assign new_game  = io.key_valid && (io.key_code == KEY_NEW) &&
                     (state != CHECK) && secret_ok;
  assign tries_inc = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;

  // Next state, buffer operations, tries and WRONG hold timer.
  always_comb begin
    state_nxt  = state;
    tries_nxt  = tries_q;
    timer_nxt  = timer;
    secret_nxt = secret;
    buf_clr    = 1'b0;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    if (new_game) begin
      secret_nxt = io.secret_in;
      tries_nxt  = '0;
      timer_nxt  = '0;
      buf_clr    = 1'b1;
      state_nxt  = ENTRY;
    end else begin
      case (state)
        ENTRY: if (io.key_valid) begin
          if (is_digit(io.key_code))          buf_push = 1'b1;
          else if (io.key_code == KEY_BKSP)   buf_pop  = 1'b1;
          else if (io.key_code == KEY_CLR)    buf_clr  = 1'b1;
          else if (io.key_code == KEY_ENTER && buf_full) state_nxt = CHECK;
        end
        CHECK: begin
          tries_nxt = tries_inc;
          if (buf_value == secret)               state_nxt = WIN;
          else if (tries_inc == 8'(MAX_TRIES))   state_nxt = LOSE;
          else begin
            state_nxt = WRONG;
            timer_nxt = TW'(SHOW_CYC - 1);
          end
        end
        WRONG: begin
          if (timer == '0) begin
            state_nxt = ENTRY;
            buf_clr   = 1'b1;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        default: ;  // IDLE, WIN, LOSE: only F acts
      endcase
    end
  end

`ifdef BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_ph, blink_ph_nxt;

  // Blink phase runs only while staying in WIN/LOSE; entry starts lit.
  always_comb begin
    blink_cnt_nxt = '0;
    blink_ph_nxt  = 1'b0;
    if ((state_nxt == WIN || state_nxt == LOSE) && state_nxt == state) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
        blink_ph_nxt  = blink_ph;
      end
    end
  end

  // Blink counter and phase.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
    end
  end

  assign blink_mask = {N_DIGITS{blink_ph_nxt}};
`else
  assign blink_mask = '0;
`endif

  // Display selection for the state being entered.
  always_comb begin
    disp_data_nxt  = buf_value_nxt;
    disp_blank_nxt = '0;
    case (state_nxt)
      IDLE:         disp_blank_nxt = '1;
      ENTRY, CHECK: for (int i = 0; i < N_DIGITS; i++)
                      disp_blank_nxt[i] = (int'(buf_count_nxt) <= i);
      WIN, LOSE: begin
        disp_data_nxt  = secret_nxt;
        disp_blank_nxt = blink_mask;
      end
      default:      disp_blank_nxt = '0;  // WRONG shows the full guess
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Game registers and registered outputs.
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      tries_q      <= '0;
      timer        <= '0;
      secret       <= '0;
      disp_data_q  <= '0;
      disp_blank_q <= '1;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      tries_q      <= tries_nxt;
      timer        <= timer_nxt;
      secret       <= secret_nxt;
      disp_data_q  <= disp_data_nxt;
      disp_blank_q <= disp_blank_nxt;
      win_q        <= (state_nxt == WIN);
      lose_q       <= (state_nxt == LOSE);
    end
  end

  assign io.disp_data  = disp_data_q;
  assign io.disp_blank = disp_blank_q;
  assign io.tries      = tries_q;
  assign io.win        = win_q;
  assign io.lose       = lose_q;
  assign io.state_o    = state;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl: a vector table walks a full game
// (entry editing, win, wrong-guess hold, lose), then hand sequences cover
// F dropped in CHECK, F at timer expiry, and reset mid-WRONG.
`timescale 1ns/1ps
module tb_guess_game_ctrl;
  localparam int SHOW = 5;

  logic clk_50M = 1'b0;
  logic RST     = 1'b1;
  always #10 clk_50M = ~clk_50M;

  guess_game_ctrl_if #(.N_DIGITS(4)) io ();

  guess_game_ctrl #(
    .N_DIGITS(4), .MAX_TRIES(2), .SHOW_CYC(SHOW), .BLINK_DIV(3)
  ) dut (
    .clk_50M (clk_50M),
    .RST     (RST),
    .io      (io.slave)
  );

  typedef struct {
    logic        kv;
    logic [3:0]  code;
    logic [15:0] sec;
    logic [2:0]  st;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [7:0]  tries;
    logic        win;
    logic        lose;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with an optional key pulse; outputs settle 1ns after the edge.
  task automatic step(input logic kv, input logic [3:0] code, input logic [15:0] sec);
    @(negedge clk_50M);
    io.key_valid = kv;
    io.key_code  = code;
    io.secret_in = sec;
    @(posedge clk_50M);
    #1;
    io.key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    step(1'b1, code, 16'h0000);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 16'h0000);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [15:0] data,
                         input logic [3:0] blank, input logic [7:0] tr,
                         input logic w, input logic l);
    chk({tag, ".state"}, 32'(io.state_o),    32'(st));
    chk({tag, ".data"},  32'(io.disp_data),  32'(data));
    chk({tag, ".blank"}, 32'(io.disp_blank), 32'(blank));
    chk({tag, ".tries"}, 32'(io.tries),      32'(tr));
    chk({tag, ".win"},   32'(io.win),        32'(w));
    chk({tag, ".lose"},  32'(io.lose),       32'(l));
  endtask

  task automatic add(input logic kv, input logic [3:0] code, input logic [15:0] sec,
                     input logic [2:0] st, input logic [15:0] data, input logic [3:0] blank,
                     input logic [7:0] tr, input logic w, input logic l);
    vecs.push_back('{kv, code, sec, st, data, blank, tr, w, l});
  endtask

  initial begin
    io.key_valid = 1'b0;
    io.key_code  = 4'h0;
    io.secret_in = 16'h0000;

    //  kv code   secret    st  data      blank tries win lose
    add(1, 4'h5, 16'h0000, 0, 16'h0000, 4'hF, 0, 0, 0);  // digit in IDLE ignored
    add(1, 4'hF, 16'h1234, 1, 16'h0000, 4'hF, 0, 0, 0);  // new game
    add(1, 4'h5, 16'h0000, 1, 16'h0005, 4'hE, 0, 0, 0);
    add(1, 4'h6, 16'h0000, 1, 16'h0056, 4'hC, 0, 0, 0);
    add(1, 4'hB, 16'h0000, 1, 16'h0005, 4'hE, 0, 0, 0);  // backspace
    add(1, 4'h7, 16'h0000, 1, 16'h0057, 4'hC, 0, 0, 0);
    add(1, 4'hA, 16'h0000, 1, 16'h0057, 4'hC, 0, 0, 0);  // enter with count 2 ignored
    add(1, 4'hF, 16'h12A4, 1, 16'h0057, 4'hC, 0, 0, 0);  // non-BCD secret ignored
    add(1, 4'hC, 16'h0000, 1, 16'h0000, 4'hF, 0, 0, 0);  // clear
    add(1, 4'h1, 16'h0000, 1, 16'h0001, 4'hE, 0, 0, 0);
    add(1, 4'h2, 16'h0000, 1, 16'h0012, 4'hC, 0, 0, 0);
    add(1, 4'h3, 16'h0000, 1, 16'h0123, 4'h8, 0, 0, 0);
    add(1, 4'h4, 16'h0000, 1, 16'h1234, 4'h0, 0, 0, 0);
    add(1, 4'h9, 16'h0000, 1, 16'h1234, 4'h0, 0, 0, 0);  // full: no wrap
    add(1, 4'hD, 16'h0000, 1, 16'h1234, 4'h0, 0, 0, 0);  // unused key
    add(1, 4'hA, 16'h0000, 2, 16'h1234, 4'h0, 0, 0, 0);  // CHECK
    add(0, 4'h0, 16'h0000, 4, 16'h1234, 4'h0, 1, 1, 0);  // WIN
    add(1, 4'h5, 16'h0000, 4, 16'h1234, 4'h0, 1, 1, 0);  // WIN holds
    add(1, 4'hF, 16'h0042, 1, 16'h0000, 4'hF, 0, 0, 0);  // restart
    add(1, 4'h9, 16'h0000, 1, 16'h0009, 4'hE, 0, 0, 0);
    add(1, 4'h9, 16'h0000, 1, 16'h0099, 4'hC, 0, 0, 0);
    add(1, 4'h9, 16'h0000, 1, 16'h0999, 4'h8, 0, 0, 0);
    add(1, 4'h9, 16'h0000, 1, 16'h9999, 4'h0, 0, 0, 0);
    add(1, 4'hA, 16'h0000, 2, 16'h9999, 4'h0, 0, 0, 0);
    add(0, 4'h0, 16'h0000, 3, 16'h9999, 4'h0, 1, 0, 0);  // WRONG, cycle 1
    add(1, 4'h5, 16'h0000, 3, 16'h9999, 4'h0, 1, 0, 0);  // cycle 2, key ignored
    add(1, 4'hB, 16'h0000, 3, 16'h9999, 4'h0, 1, 0, 0);  // cycle 3
    add(1, 4'hC, 16'h0000, 3, 16'h9999, 4'h0, 1, 0, 0);  // cycle 4
    add(0, 4'h0, 16'h0000, 3, 16'h9999, 4'h0, 1, 0, 0);  // cycle 5
    add(0, 4'h0, 16'h0000, 1, 16'h0000, 4'hF, 1, 0, 0);  // back to ENTRY
    add(1, 4'h1, 16'h0000, 1, 16'h0001, 4'hE, 1, 0, 0);
    add(1, 4'h1, 16'h0000, 1, 16'h0011, 4'hC, 1, 0, 0);
    add(1, 4'h1, 16'h0000, 1, 16'h0111, 4'h8, 1, 0, 0);
    add(1, 4'h1, 16'h0000, 1, 16'h1111, 4'h0, 1, 0, 0);
    add(1, 4'hA, 16'h0000, 2, 16'h1111, 4'h0, 1, 0, 0);
    add(0, 4'h0, 16'h0000, 5, 16'h0042, 4'h0, 2, 0, 1);  // LOSE
    add(1, 4'h0, 16'h0000, 5, 16'h0042, 4'h0, 2, 0, 1);  // LOSE holds
    add(1, 4'hF, 16'h1234, 1, 16'h0000, 4'hF, 0, 0, 0);  // restart

    // Reset state
    repeat (2) @(posedge clk_50M);
    #1;
    chk_all("reset", 3'd0, 16'h0000, 4'hF, 8'd0, 1'b0, 1'b0);
    @(negedge clk_50M);
    RST = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].code, vecs[i].sec);
      chk_all($sformatf("v%0d", i), vecs[i].st, vecs[i].data, vecs[i].blank,
              vecs[i].tries, vecs[i].win, vecs[i].lose);
    end

    // F during CHECK is dropped; F on the expiry cycle of WRONG restarts.
    press(4'h5); press(4'h5); press(4'h5); press(4'h5);
    press(4'hA);
    chk("seqA.check", 32'(io.state_o), 32'd2);
    step(1'b1, 4'hF, 16'h0008);
    chk("seqA.f_in_check.state", 32'(io.state_o), 32'd3);
    chk("seqA.f_in_check.tries", 32'(io.tries),   32'd1);
    repeat (SHOW - 1) idle();
    chk("seqA.last_wrong", 32'(io.state_o), 32'd3);
    step(1'b1, 4'hF, 16'h0007);
    chk_all("seqA.f_at_expiry", 3'd1, 16'h0000, 4'hF, 8'd0, 1'b0, 1'b0);
    press(4'h0); press(4'h0); press(4'h0); press(4'h7);
    press(4'hA);
    idle();
    chk_all("seqA.win", 3'd4, 16'h0007, 4'h0, 8'd1, 1'b1, 1'b0);

    // Reset asserted mid-WRONG clears everything at once.
    step(1'b1, 4'hF, 16'h1234);
    press(4'h1); press(4'h1); press(4'h1); press(4'h1);
    press(4'hA);
    idle();
    idle();
    chk("seqB.in_wrong", 32'(io.state_o), 32'd3);
    @(negedge clk_50M);
    RST = 1'b1;
    #1;
    chk_all("seqB.async", 3'd0, 16'h0000, 4'hF, 8'd0, 1'b0, 1'b0);
    @(posedge clk_50M);
    #1;
    chk_all("seqB.held", 3'd0, 16'h0000, 4'hF, 8'd0, 1'b0, 1'b0);
    @(negedge clk_50M);
    RST = 1'b0;
    repeat (SHOW + 1) idle();
    chk_all("seqB.idle", 3'd0, 16'h0000, 4'hF, 8'd0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 16'h1234);
    chk_all("seqB.restart", 3'd1, 16'h0000, 4'hF, 8'd0, 1'b0, 1'b0);
    press(4'h4);
    chk_all("seqB.digit", 3'd1, 16'h0004, 4'hE, 8'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the main sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected summary within 200us");
    $fatal(1, "timeout");
  end
endmodule
